// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, latency constants and op-class helpers
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
import mdu_pkg::*;

module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUop,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    mdu_state_e  state;
    mdu_state_e  state_next;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_skip;

    logic        mul_op;
    logic        div_op;
    logic        launch;
    logic        commit;

    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign mul_op = is_mul_op(MDUop);
    assign div_op = is_div_op(MDUop);
    assign launch = (state == ST_IDLE) && Start && (mul_op || div_op);
    assign commit = (state == ST_BUSY) && (cnt <= 4'd1);
    assign Busy   = (state == ST_BUSY);

    // Launch-cycle result: the multiply works on sign- or zero-extended 64-bit
    // operands; the divide works on magnitudes so that 0x80000000 / -1 wraps
    // to 0x80000000 instead of overflowing, and a zero divisor is replaced by 1
    // (its result is never committed).
    always_comb begin
        prod    = '0;
        neg_a   = 1'b0;
        neg_b   = 1'b0;
        abs_a   = A;
        abs_b   = B;
        divisor = 32'd1;
        q_mag   = '0;
        r_mag   = '0;
        quot    = '0;
        rem     = '0;
        res_hi  = '0;
        res_lo  = '0;
        if (mul_op) begin
            if (MDUop == MDU_MULT)
                prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            else
                prod = {32'd0, A} * {32'd0, B};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (div_op) begin
            neg_a   = (MDUop == MDU_DIV) && A[31];
            neg_b   = (MDUop == MDU_DIV) && B[31];
            abs_a   = neg_a ? (32'd0 - A) : A;
            abs_b   = neg_b ? (32'd0 - B) : B;
            divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
            q_mag   = abs_a / divisor;
            r_mag   = abs_a % divisor;
            quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
            rem     = neg_a ? (32'd0 - r_mag) : r_mag;
            res_hi  = rem;
            res_lo  = quot;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state: leave IDLE on a launch, return when the counter expires.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch) state_next = ST_BUSY;
            ST_BUSY: if (commit) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter, pending result and architectural HI/LO; launch beats MT writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= 4'd0;
            p_hi   <= '0;
            p_lo   <= '0;
            p_skip <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else if (launch) begin
            cnt    <= div_op ? DIV_CYCLES : MULT_CYCLES;
            p_hi   <= res_hi;
            p_lo   <= res_lo;
            p_skip <= div_op && (B == 32'd0);
        end else if (state == ST_BUSY) begin
            cnt <= cnt - 4'd1;
            if (commit && !p_skip) begin
                HI <= p_hi;
                LO <= p_lo;
            end
        end else begin
            if (MDUop == MDU_MTHI) HI <= A;
            if (MDUop == MDU_MTLO) LO <= A;
        end
    end

    // Move-from read port.
    always_comb begin
        MDUout = '0;
        if (MDUop == MDU_MFHI)      MDUout = HI;
        else if (MDUop == MDU_MFLO) MDUout = LO;
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard testbench for mdu with a high-level arithmetic model
import mdu_pkg::*;

module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUop;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUop  (MDUop),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUout (MDUout)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every falling edge of Busy retires one scoreboard entry.
    initial begin
        logic prev_busy;
        int   busy_len;
        exp_t e;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (Busy === 1'b1) begin
                busy_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("commit_hi", HI, e.hi);
                    chk("commit_lo", LO, e.lo);
                    chk("busy_cycles", busy_len, e.len);
                end
                busy_len = 0;
            end
            prev_busy = (Busy === 1'b1);
        end
    end

    // Reference arithmetic: 64-bit integer math straight from the op definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int len);
        longint          sa, sb_, q, r;
        longint unsigned ua, ub, uq, ur, up;
        longint          sp;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        hi = m_hi;
        lo = m_lo;
        len = (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
        case (op)
            MDU_MULT: begin
                sp = sa * sb_;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            MDU_MULTU: begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            MDU_DIV: if (b != 32'd0) begin
                q = sa / sb_;
                r = sa % sb_;
                hi = r[31:0];
                lo = q[31:0];
            end
            MDU_DIVU: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                hi = ur[31:0];
                lo = uq[31:0];
            end
            default: ;
        endcase
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input int restart_at);
        exp_t        e;
        logic [31:0] old_lo;
        int          cyc;
        old_lo = m_lo;
        model(op, a, b, e.hi, e.lo, e.len);
        if (abort_at > 0) begin
            e.hi = 32'd0;
            e.lo = 32'd0;
            e.len = abort_at;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
        MDUop = op; A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        MDUop = MDU_MFLO;
        A = $urandom; B = $urandom;
        #1;
        chk("mflo_no_forward", MDUout, old_lo);
        cyc = 1;
        forever begin
            if (cyc == restart_at) begin
                MDUop = MDU_MULT; A = $urandom; B = $urandom; Start = 1'b1;
            end else begin
                MDUop = MDU_NONE; Start = 1'b0;
            end
            reset = (cyc == abort_at) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (Busy !== 1'b1) break;
            if (cyc > 30) begin
                chk("busy_timeout", 32'd1, 32'd0);
                break;
            end
        end
        reset = 1'b1; Start = 1'b0; MDUop = MDU_NONE;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        MDUop = op; A = a;
        @(posedge clk); #1;
        MDUop = MDU_NONE;
        if (op == MDU_MTHI) m_hi = a;
        else m_lo = a;
    endtask

    task automatic mf_check();
        MDUop = MDU_MFHI; #1;
        chk("mfhi", MDUout, m_hi);
        MDUop = MDU_MFLO; #1;
        chk("mflo", MDUout, m_lo);
        MDUop = MDU_NONE; #1;
        chk("none_out", MDUout, 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b0; Start = 1'b0; MDUop = MDU_NONE; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_mdu_out", MDUout, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, 0, 0);
        mf_check();
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 0, 0);
        mf_check();
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
        mf_check();
        run_op(MDU_DIVU, 32'd7, 32'd2, 0, 0);
        mf_check();
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        mf_check();

        mt(MDU_MTHI, 32'h1234);
        mf_check();
        run_op(MDU_DIV, 32'd99, 32'd0, 0, 0);
        mf_check();
        run_op(MDU_MULT, 32'd6, 32'hFFFFFFFE, 0, 3);
        mf_check();

        MDUop = 4'hF; A = $urandom;
        #1;
        chk("unused_op_out", MDUout, 32'd0);
        @(posedge clk); #1;
        MDUop = MDU_NONE;
        mf_check();

        run_op(MDU_MULTU, 32'hDEADBEEF, 32'h12345678, 2, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_hi_stays", HI, 32'd0);
        chk("abort_lo_stays", LO, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            case (op)
                4'd5: mt(MDU_MTHI, a);
                4'd6: mt(MDU_MTLO, a);
                default: run_op(op, a, b, 0, ($urandom_range(0, 2) == 0) ? 2 : 0);
            endcase
            mf_check();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
